// File: rtl/tft_pkg.sv
// Shared TFT definitions: SPI transmitter state encoding, panel command
// opcodes used by the drawing blocks, and the byte request payload.
package tft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } tft_state_e;

  localparam logic [7:0] TFT_CMD_CASET = 8'h2a;  // column address set
  localparam logic [7:0] TFT_CMD_RASET = 8'h2b;  // row address set
  localparam logic [7:0] TFT_CMD_RAMWR = 8'h2c;  // memory write

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } tft_byte_t;

endpackage

// File: rtl/tft_spi_if.sv
// Byte handshake between a drawing block (master) and the SPI transmitter
// (slave).
//   tft_transmit : request to send tft_data with flag tft_dc
//   tft_dc       : 0 = command byte, 1 = data byte
//   tft_data     : byte to send
//   tft_busy     : byte in flight
interface tft_spi_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (output tft_transmit, output tft_dc, output tft_data, input tft_busy);
  modport slave  (input tft_transmit, input tft_dc, input tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tick.sv
// SCK half-period divider with synchronous clear.
//   clk, rst_n  : clock, async active-low reset
//   clr_i       : restart the count (held while no byte is in flight)
//   phase_end_o : registered 1-cycle pulse during the last cycle of a phase
module spi_tick #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic phase_end_o
);

  localparam int unsigned CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pe_q, pe_d;

  // Pulse is registered from the next count so it lines up with that count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(CLK_DIV - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    pe_d = (cnt_d == CW'(CLK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pe_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pe_q  <= pe_d;
    end
  end

  assign phase_end_o = pe_q;

endmodule

// File: rtl/tft_spi.sv
// Byte-level SPI mode-0 transmitter for the TFT panel, MSB first, with
// chip-select hold between bytes and a registered D/C pin.
//   clk, rst_n : clock, async active-low reset
//   bus        : byte handshake (tft_transmit/tft_dc/tft_data in, tft_busy out)
//   spi_sck    : SPI clock, idles low
//   spi_mosi   : serial data
//   spi_cs_n   : panel chip-select, active low
//   spi_dc     : panel D/C, latched at accept
module tft_spi
  import tft_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  tft_spi_if.slave    bus,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        spi_dc
);

  localparam int unsigned IW = (CS_IDLE > 0) ? $clog2(CS_IDLE + 1) : 1;

  tft_state_e    state_q, state_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          busy_q, busy_d;
  logic          sck_q, sck_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          dc_q, dc_d;

  tft_byte_t     req_c;
  logic          accept_c;
  logic          tick_clr_c;
  logic          phase_end;

  assign req_c      = {bus.tft_dc, bus.tft_data};
  assign accept_c   = (state_q == ST_IDLE || state_q == ST_HOLD) && !busy_q && bus.tft_transmit;
  assign tick_clr_c = accept_c || (state_q != ST_SHIFT);

  spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (tick_clr_c),
    .phase_end_o (phase_end)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    idle_d  = idle_q;
    busy_d  = busy_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    dc_d    = dc_q;

    unique case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept_c) begin
          shreg_d = req_c.data;
          dc_d    = req_c.dc;
          mosi_d  = req_c.data[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          sck_d   = 1'b0;
          bit_d   = 3'd0;
          state_d = ST_SHIFT;
        end else if (state_q == ST_HOLD) begin
          // Saturating idle count; CS released when it reaches CS_IDLE.
          if (idle_q != IW'(CS_IDLE)) begin
            idle_d = idle_q + IW'(1);
          end
          if (idle_d == IW'(CS_IDLE)) begin
            cs_n_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      ST_SHIFT: begin
        if (phase_end) begin
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (bit_q == 3'd7) begin
              // Last bit done: MOSI keeps the LSB.
              busy_d = 1'b0;
              idle_d = '0;
              if (CS_IDLE == 0) begin
                cs_n_d  = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_HOLD;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              shreg_d = {shreg_q[6:0], 1'b0};
              mosi_d  = shreg_q[6];
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
        sck_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      idle_q  <= '0;
      busy_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      idle_q  <= idle_d;
      busy_q  <= busy_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      dc_q    <= dc_d;
    end
  end

  assign bus.tft_busy = busy_q;
  assign spi_sck      = sck_q;
  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;
  assign spi_dc       = dc_q;

endmodule

// File: tb/tb_tft_spi.sv
// Bench for tft_spi: two instances (CLK_DIV=2/CS_IDLE=4 and CLK_DIV=1/CS_IDLE=0)
// checked every cycle against a timing model derived from accept times.
module tb_tft_spi;
  import tft_pkg::*;

  localparam int D0 = 2, I0 = 4, D1 = 1, I1 = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tft_spi_if if0 ();
  tft_spi_if if1 ();

  wire [1:0] sck_v, mosi_v, cs_v, dc_v;
  wire [1:0] busy_v = {if1.tft_busy, if0.tft_busy};
  wire [1:0] tx_v   = {if1.tft_transmit, if0.tft_transmit};

  tft_spi #(.CLK_DIV(D0), .CS_IDLE(I0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave),
    .spi_sck(sck_v[0]), .spi_mosi(mosi_v[0]), .spi_cs_n(cs_v[0]), .spi_dc(dc_v[0]));
  tft_spi #(.CLK_DIV(D1), .CS_IDLE(I1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .spi_sck(sck_v[1]), .spi_mosi(mosi_v[1]), .spi_cs_n(cs_v[1]), .spi_dc(dc_v[1]));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(string nm, int act, int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         have  [2];
  int         t_acc [2];
  logic [7:0] m_byte[2];
  logic       m_dc  [2];
  int         cyc = 0;

  function automatic int dv(int i); return (i == 0) ? D0 : D1; endfunction
  function automatic int iv(int i); return (i == 0) ? I0 : I1; endfunction

  // {busy, sck, mosi, cs_n, dc} expected after edge c.
  function automatic logic [4:0] exp_out(int i, int c);
    int el, n, ph;
    if (!rst_n || !have[i]) return 5'b00010;
    el = c - t_acc[i];
    n  = 16 * dv(i);
    if (el < n) begin
      ph = el / dv(i);
      return {1'b1, ph[0], m_byte[i][7 - ph/2], 1'b0, m_dc[i]};
    end
    return {1'b0, 1'b0, m_byte[i][0], (el - n >= iv(i)), m_dc[i]};
  endfunction

  always @(posedge clk) begin
    logic [4:0] e0, e1;
    e0 = exp_out(0, cyc);
    e1 = exp_out(1, cyc);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        have[i] = 1'b0;
      end else if (tx_v[i] && !((i == 0) ? e0[4] : e1[4])) begin
        have[i]   = 1'b1;
        t_acc[i]  = cyc;
        m_byte[i] = (i == 0) ? if0.tft_data : if1.tft_data;
        m_dc[i]   = (i == 0) ? if0.tft_dc : if1.tft_dc;
      end
    end
  end

  // ---------------- compare + monitors ----------------
  logic [7:0] rx0[$], rx1[$];
  int         gap_q[$];
  logic [7:0] sh    [2];
  int         bitc  [2] = '{0, 0};
  int         rises [2] = '{0, 0};
  int         hcnt  [2] = '{0, 0};
  int         lcnt  [2] = '{0, 0};
  int         last_len[2] = '{0, 0};
  int         cs_delay[2] = '{-1, -1};
  int         ccnt  [2] = '{0, 0};
  bit         cfollow[2];
  int         cs_hi [2] = '{0, 0};
  bit         win   [2];
  logic       psck  [2] = '{1'b0, 1'b0};
  logic       pbusy [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [4:0] act;
      act = {busy_v[i], sck_v[i], mosi_v[i], cs_v[i], dc_v[i]};
      chk($sformatf("u%0d {busy,sck,mosi,cs_n,dc} cyc%0d", i, cyc), int'(act), int'(exp_out(i, cyc)));

      if (!rst_n) begin
        bitc[i] = 0;
      end else if (sck_v[i] && !psck[i]) begin
        sh[i] = {sh[i][6:0], mosi_v[i]};
        bitc[i]++;
        rises[i]++;
        if (bitc[i] == 8) begin
          if (i == 0) rx0.push_back(sh[i]); else rx1.push_back(sh[i]);
          bitc[i] = 0;
        end
      end

      if (busy_v[i]) hcnt[i]++;
      if (!busy_v[i] && pbusy[i]) last_len[i] = hcnt[i];
      if (!busy_v[i]) hcnt[i] = 0;

      if (i == 0 && busy_v[i] && !pbusy[i]) gap_q.push_back(lcnt[i]);
      if (busy_v[i]) lcnt[i] = 0; else lcnt[i]++;

      if (pbusy[i] && !busy_v[i]) begin
        cfollow[i] = 1'b1;
        ccnt[i]    = 0;
      end
      if (cfollow[i]) begin
        if (cs_v[i]) begin
          cs_delay[i] = ccnt[i];
          cfollow[i]  = 1'b0;
        end else if (busy_v[i]) begin
          cfollow[i] = 1'b0;
        end else begin
          ccnt[i]++;
        end
      end

      if (win[i] && cs_v[i]) cs_hi[i]++;
      psck[i]  = sck_v[i];
      pbusy[i] = busy_v[i];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(int i, logic tx, logic [7:0] d, logic dc);
    if (i == 0) begin
      if0.tft_transmit = tx; if0.tft_data = d; if0.tft_dc = dc;
    end else begin
      if1.tft_transmit = tx; if1.tft_data = d; if1.tft_dc = dc;
    end
  endtask

  task automatic wait_busy(int i, logic v, int budget, string nm);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (busy_v[i] === v) return;
    end
    n_total++; n_bad++;
    $display("FAIL %s: timeout waiting for busy=%0b on u%0d", nm, v, i);
  endtask

  task automatic wait_cs_high(int i, int budget, string nm);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (cs_v[i] === 1'b1) return;
    end
    n_total++; n_bad++;
    $display("FAIL %s: timeout waiting for cs_n=1 on u%0d", nm, i);
  endtask

  task automatic send(int i, logic [7:0] b, logic dc);
    wait_busy(i, 1'b0, 100, "send idle");
    @(posedge clk); #1 drive(i, 1'b1, b, dc);
    wait_busy(i, 1'b1, 10, "send start");
    @(posedge clk); #1 drive(i, 1'b0, b, dc);
    wait_busy(i, 1'b0, 100, "send end");
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] seq[5];
    int  idx, budget, r0;
    bit  tx, b;
    seq = '{TFT_CMD_CASET, 8'h00, 8'h0a, 8'h00, 8'h13};

    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", busy_v[0], 0);
    chk("reset sck",  sck_v[0],  0);
    chk("reset mosi", mosi_v[0], 0);
    chk("reset cs_n", cs_v[0],   1);
    chk("reset dc",   dc_v[0],   0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single data byte A5.
    rx0.delete();
    send(0, 8'hA5, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5 byte count", rx0.size(), 1);
    if (rx0.size() > 0) chk("a5 mosi at rises", rx0[0], 8'hA5);
    chk("a5 busy length", last_len[0], 32);
    chk("a5 spi_dc", dc_v[0], 1);

    // Command byte 2a and CS hold timeout.
    wait_cs_high(0, 50, "pre 2a idle");
    rx0.delete();
    cs_delay[0] = -1;
    send(0, TFT_CMD_CASET, 1'b0);
    wait_cs_high(0, 50, "2a cs release");
    chk("2a cs delay after busy", cs_delay[0], 4);
    chk("2a spi_dc", dc_v[0], 0);
    if (rx0.size() > 0) chk("2a byte", rx0[0], 8'h2a);

    // Back-to-back bytes from a registered upstream.
    wait_cs_high(0, 50, "pre b2b idle");
    rx0.delete(); gap_q.delete(); cs_hi[0] = 0;
    idx = 0; tx = 1'b0; b = 1'b0; budget = 0;
    while ((idx < 5 || b) && budget < 2000) begin
      @(negedge clk);
      b = busy_v[0];
      if (b) win[0] = 1'b1;
      @(posedge clk); #1;
      if (tx && b) begin
        tx = 1'b0; idx++;
      end else if (!tx && !b && idx < 5) begin
        tx = 1'b1;
      end
      drive(0, tx, seq[(idx < 5) ? idx : 4], (idx != 0));
      budget++;
    end
    win[0] = 1'b0;
    chk("b2b finished in budget", int'(budget < 2000), 1);
    chk("b2b byte count", rx0.size(), 5);
    for (int k = 0; k < 5; k++)
      if (k < rx0.size()) chk($sformatf("b2b byte%0d", k), rx0[k], seq[k]);
    chk("b2b cs_n high samples", cs_hi[0], 0);
    chk("b2b accept count", gap_q.size(), 5);
    for (int k = 1; k < 5; k++)
      if (k < gap_q.size()) chk($sformatf("b2b gap%0d", k), gap_q[k], 2);

    // Request during SHIFT is ignored.
    wait_cs_high(0, 50, "pre ignore idle");
    rx0.delete();
    @(posedge clk); #1 drive(0, 1'b1, 8'h00, 1'b1);
    wait_busy(0, 1'b1, 10, "ignore start");
    repeat (8) @(posedge clk);
    #1 drive(0, 1'b1, 8'hFF, 1'b0);
    repeat (6) @(posedge clk);
    #1 drive(0, 1'b0, 8'hFF, 1'b0);
    wait_busy(0, 1'b0, 100, "ignore end");
    repeat (10) @(negedge clk);
    chk("ignore byte count", rx0.size(), 1);
    if (rx0.size() > 0) chk("ignore byte", rx0[0], 8'h00);
    chk("ignore no restart", busy_v[0], 0);

    // Reset during the 3rd SCK high phase.
    wait_cs_high(0, 50, "pre reset idle");
    rx0.delete();
    r0 = rises[0];
    @(posedge clk); #1 drive(0, 1'b1, 8'hC3, 1'b1);
    wait_busy(0, 1'b1, 10, "reset byte start");
    @(posedge clk); #1 drive(0, 1'b0, 8'hC3, 1'b1);
    budget = 0;
    while (rises[0] < r0 + 3 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk("third rise seen", int'(rises[0] >= r0 + 3), 1);
    chk("sck high before reset", sck_v[0], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid-byte reset sck",  sck_v[0],  0);
    chk("mid-byte reset cs_n", cs_v[0],   1);
    chk("mid-byte reset busy", busy_v[0], 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(0, 8'h3C, 1'b1);
    repeat (2) @(negedge clk);
    chk("after reset byte count", rx0.size(), 1);
    if (rx0.size() > 0) chk("after reset byte", rx0[0], 8'h3C);

    // Fastest configuration, no CS hold.
    rx1.delete();
    cs_delay[1] = -1;
    send(1, TFT_CMD_RAMWR, 1'b0);
    repeat (3) @(negedge clk);
    chk("div1 busy length", last_len[1], 16);
    chk("div1 cs with busy fall", cs_delay[1], 0);
    chk("div1 byte count", rx1.size(), 1);
    if (rx1.size() > 0) chk("div1 byte", rx1[0], 8'h2c);

    // Random requests, data churn and occasional resets.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst_n = ($urandom_range(0, 999) != 0);
      drive(0, ($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom));
      drive(1, ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, TFT_CMD_RASET, 1'b0);
    repeat (50) @(posedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
